// File: rtl/trace_queue.sv
// Retire/writeback trace queue: filters records that carry nothing to trace, buffers
// them in a circular store and replays them one per drain cycle on a registered port.
module trace_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_iv,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_rdv,
  input  logic [4:0]               in_rd_x,
  input  logic [31:0]              in_rd_data,
  input  logic                     in_pcv,
  input  logic [31:0]              in_pc_x,
  input  logic                     drain,
  output logic                     valid,
  output logic [31:0]              pc,
  output logic [31:0]              inst,
  output logic                     rdv,
  output logic [4:0]               rd_x,
  output logic [31:0]              rd_data,
  output logic                     pcv,
  output logic [31:0]              pc_x,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd_x;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          in_rec;
  rec_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rdv_filt;
  logic          accept;
  logic          keep;
  logic          pop;

  // Gating with reset keeps the handshake closed while the queue is held in reset.
  assign in_ready = reset && (count < FULL);
  assign accept   = in_valid && in_ready;

  // x0 destination writes carry no architectural effect, so they are not traced.
  assign rdv_filt = in_rdv && (in_rd_x != 5'd0);
  assign keep     = accept && (in_iv || rdv_filt || in_pcv);
  assign pop      = drain && (count != '0);

  assign in_rec = '{iv: in_iv, pc: in_pc, inst: in_inst, rdv: rdv_filt, rd_x: in_rd_x,
                    rd_data: in_rd_data, pcv: in_pcv, pc_x: in_pc_x};
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (keep) mem[wr_ptr] <= in_rec;
  end

  // Pointer width equals log2(DEPTH), so increments wrap to 0 on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (keep) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({keep, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_valid && (count == FULL)) overflow <= 1'b1;
    end
  end

  // Strobes drop to 0 between pops; data fields keep the last emitted record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid   <= 1'b0;
      pc      <= '0;
      inst    <= '0;
      rdv     <= 1'b0;
      rd_x    <= '0;
      rd_data <= '0;
      pcv     <= 1'b0;
      pc_x    <= '0;
    end else if (pop) begin
      valid   <= 1'b1;
      pc      <= head.pc;
      inst    <= head.inst;
      rdv     <= head.rdv;
      rd_x    <= head.rd_x;
      rd_data <= head.rd_data;
      pcv     <= head.pcv;
      pc_x    <= head.pc_x;
    end else begin
      valid <= 1'b0;
      rdv   <= 1'b0;
      pcv   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trace_queue.sv
// Self-checking bench for trace_queue (DEPTH=4): scenario tasks plus an
// in-order scoreboard of the records expected on the trace port.
module tb_trace_queue;

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd_x;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
  } rec_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_iv;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_rdv;
  logic [4:0]  in_rd_x;
  logic [31:0] in_rd_data;
  logic        in_pcv;
  logic [31:0] in_pc_x;
  logic        drain;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        rdv;
  logic [4:0]  rd_x;
  logic [31:0] rd_data;
  logic        pcv;
  logic [31:0] pc_x;
  logic [2:0]  count;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  int   n_emit = 0;
  rec_t sbq[$];

  trace_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_iv(in_iv), .in_pc(in_pc), .in_inst(in_inst), .in_rdv(in_rdv),
    .in_rd_x(in_rd_x), .in_rd_data(in_rd_data), .in_pcv(in_pcv), .in_pc_x(in_pc_x),
    .drain(drain), .valid(valid), .pc(pc), .inst(inst), .rdv(rdv), .rd_x(rd_x),
    .rd_data(rd_data), .pcv(pcv), .pc_x(pc_x), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t mk(logic iv, logic [31:0] p, logic [31:0] ins, logic rv,
                              logic [4:0] rx, logic [31:0] rdat, logic pv, logic [31:0] px);
    rec_t r;
    r = '{iv: iv, pc: p, inst: ins, rdv: rv, rd_x: rx, rd_data: rdat, pcv: pv, pc_x: px};
    return r;
  endfunction

  // Offer a record for the next edge; if the scenario expects it stored, queue
  // its expected trace-port image (x0 destination writes show rdv=0).
  task automatic drive(input rec_t r, input bit exp_store);
    rec_t e;
    in_valid   = 1'b1;
    in_iv      = r.iv;
    in_pc      = r.pc;
    in_inst    = r.inst;
    in_rdv     = r.rdv;
    in_rd_x    = r.rd_x;
    in_rd_data = r.rd_data;
    in_pcv     = r.pcv;
    in_pc_x    = r.pc_x;
    if (exp_store) begin
      e = r;
      if (r.rd_x == 5'd0) e.rdv = 1'b0;
      sbq.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every strobe seen on the port must match the oldest expected record.
  initial begin
    rec_t got;
    rec_t exp_r;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n_emit++;
        checks++;
        got = {1'b0, pc, inst, rdv, rd_x, rd_data, pcv, pc_x};
        got.iv = 1'b0;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL spurious_emit got pc=%h rd_x=%0d expected no strobe", pc, rd_x);
        end else begin
          exp_r = sbq.pop_front();
          exp_r.iv = 1'b0;
          if (got !== exp_r)
            begin
              errors++;
              $display("FAIL scoreboard got pc=%h inst=%h rdv=%b rd_x=%0d rd_data=%h pcv=%b pc_x=%h expected pc=%h inst=%h rdv=%b rd_x=%0d rd_data=%h pcv=%b pc_x=%h",
                       got.pc, got.inst, got.rdv, got.rd_x, got.rd_data, got.pcv, got.pc_x,
                       exp_r.pc, exp_r.inst, exp_r.rdv, exp_r.rd_x, exp_r.rd_data, exp_r.pcv, exp_r.pc_x);
            end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; drain = 1'b1; in_valid = 1'b1;
    in_iv = 1'b1; in_pc = 32'h40; in_inst = 32'h13; in_rdv = 1'b1; in_rd_x = 5'd3;
    in_rd_data = 32'h55; in_pcv = 1'b0; in_pc_x = 32'h0;
    step(); step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", in_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    checks++; if ({valid, rdv, pcv, pc, rd_data} !== 67'd0) begin errors++; $display("FAIL reset_outputs got valid=%b pc=%h rd_data=%h expected zeros", valid, pc, rd_data); end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b expected 1", in_ready); end
  endtask

  task automatic test_pass_through();
    drain = 1'b1;
    drive(mk(1'b1, 32'h0, 32'h00100093, 1'b1, 5'd1, 32'h1, 1'b0, 32'h0), 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pt_no_bypass got valid=%b expected 0", valid); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL pt_count got %0d expected 1", count); end
    step();
    checks++; if ({valid, pc, rd_x, rd_data} !== {1'b1, 32'h0, 5'd1, 32'h1}) begin errors++; $display("FAIL pt_emit got valid=%b pc=%h rd_x=%0d rd_data=%h expected 1/0/1/1", valid, pc, rd_x, rd_data); end
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pt_pulse got valid=%b expected 0", valid); end
    checks++; if (rd_data !== 32'h1) begin errors++; $display("FAIL pt_hold got rd_data=%h expected 1", rd_data); end
  endtask

  task automatic test_x0_filter();
    int e0;
    drain = 1'b1;
    drive(mk(1'b0, 32'h100, 32'h0, 1'b1, 5'd0, 32'hABCD, 1'b0, 32'h0), 1'b0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_handshake got in_ready=%b expected 1", in_ready); end
    e0 = n_emit;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL x0_discard_count got %0d expected 0", count); end
    step(); step();
    checks++; if (n_emit !== e0) begin errors++; $display("FAIL x0_no_strobe got %0d strobes expected 0", n_emit - e0); end
    drive(mk(1'b1, 32'h104, 32'h00000013, 1'b1, 5'd0, 32'h77, 1'b0, 32'h0), 1'b1);
    step();
    in_valid = 1'b0;
    step();
    checks++; if ({valid, rdv, inst} !== {1'b1, 1'b0, 32'h13}) begin errors++; $display("FAIL x0_rdv_cleared got valid=%b rdv=%b inst=%h expected 1/0/13", valid, rdv, inst); end
    step();
  endtask

  task automatic test_fill_overflow();
    drain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(mk(1'b1, 32'(i * 4), 32'h13 + 32'(i), 1'b1, 5'(i + 2), 32'h1000 + 32'(i), 1'b1, 32'h2000 + 32'(i)), i < 4);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b expected 0", in_ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b expected 1", overflow); end
    // A pop at the same edge as an offer while full must not admit the offer.
    drain = 1'b1;
    drive(mk(1'b1, 32'h14, 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0), 1'b0);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d expected 3", count); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++; if ({valid, pc} !== {1'b1, 32'(k * 4)}) begin errors++; $display("FAIL drain_seq%0d got valid=%b pc=%h expected 1/%h", k, valid, pc, 32'(k * 4)); end
    end
    step();
    checks++; if ({valid, count} !== {1'b0, 3'd0}) begin errors++; $display("FAIL drain_end got valid=%b count=%0d expected 0/0", valid, count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b expected 1", overflow); end
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = n_emit;
    drain = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(mk(1'b1, 32'h300 + 32'(i * 4), 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 32'h900 + 32'(i)), 1'b1);
      step();
    end
    drain = 1'b1;
    for (int i = 2; i < 10; i++) begin
      drive(mk(1'b1, 32'h300 + 32'(i * 4), 32'h33, 1'b1, 5'(i), 32'h500 + 32'(i), 1'b0, 32'h0), 1'b1);
      step();
      checks++; if ({valid, count} !== {1'b1, 3'd2}) begin errors++; $display("FAIL b2b_%0d got valid=%b count=%0d expected 1/2", i, valid, count); end
    end
    in_valid = 1'b0;
    step();
    checks++; if ({valid, count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL b2b_drain got valid=%b count=%0d expected 1/1", valid, count); end
    drive(mk(1'b1, 32'h328, 32'h33, 1'b1, 5'd31, 32'h5FF, 1'b1, 32'h9FF), 1'b1);
    step();
    in_valid = 1'b0;
    checks++; if ({valid, count} !== {1'b1, 3'd1}) begin errors++; $display("FAIL b2b_count1 got valid=%b count=%0d expected 1/1", valid, count); end
    step();
    checks++; if ({valid, count} !== {1'b1, 3'd0}) begin errors++; $display("FAIL b2b_last got valid=%b count=%0d expected 1/0", valid, count); end
    step();
    checks++; if (n_emit - e0 !== 11) begin errors++; $display("FAIL b2b_total got %0d strobes expected 11", n_emit - e0); end
  endtask

  task automatic test_reset_mid();
    int e0;
    drain = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 32'h700 + 32'(i * 4), 32'h13, 1'b1, 5'd7, 32'hBEEF, 1'b0, 32'h0), 1'b1);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_queued got %0d expected 3", count); end
    reset = 1'b0;
    #1;
    checks++; if ({count, valid, in_ready, overflow} !== 6'd0) begin errors++; $display("FAIL mid_async got count=%0d valid=%b in_ready=%b overflow=%b expected all 0", count, valid, in_ready, overflow); end
    checks++; if ({pc, rd_data} !== 64'd0) begin errors++; $display("FAIL mid_data_clear got pc=%h rd_data=%h expected 0", pc, rd_data); end
    sbq.delete();
    step();
    reset = 1'b1;
    drain = 1'b1;
    e0 = n_emit;
    repeat (5) step();
    checks++; if (n_emit !== e0) begin errors++; $display("FAIL mid_no_replay got %0d strobes expected 0", n_emit - e0); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_x0_filter();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d records pending expected 0", sbq.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
